// File: rtl/axi4_lite_req_arbiter_pkg.sv
// Shared AXI4-Lite definitions: bus widths, the request arbiter's state type
// and its default response timeout.
package axi4_lite_Defs;

    localparam int Addr_Width  = 32;
    localparam int Data_Width  = 32;
    localparam int ARB_TIMEOUT = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/axi4_lite_req_arbiter_if.sv
// Command/response signals between the request arbiter and the AXI4-Lite master.
interface axi4_lite_req_arbiter_if
    import axi4_lite_Defs::*;
#(
    parameter int ADDR_WIDTH = Addr_Width,
    parameter int DATA_WIDTH = Data_Width
);
    logic                  rd_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] Read_Address;
    logic [ADDR_WIDTH-1:0] Write_Address;
    logic [DATA_WIDTH-1:0] Write_Data;

    // R/B beats transfer on a cycle where valid and ready are both high; the
    // arbiter only watches these, it never drives valid or ready itself.
    logic                  bus_rvalid;
    logic                  bus_rready;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_bvalid;
    logic                  bus_bready;

    modport master (
        output rd_en, wr_en, Read_Address, Write_Address, Write_Data,
        input  bus_rvalid, bus_rready, bus_rdata, bus_bvalid, bus_bready
    );

    modport slave (
        input  rd_en, wr_en, Read_Address, Write_Address, Write_Data,
        output bus_rvalid, bus_rready, bus_rdata, bus_bvalid, bus_bready
    );

endinterface

// File: rtl/axi4_lite_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request searching upward
// from ptr+1 with wrap-around.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    // Scan farthest-to-nearest so the nearest candidate after ptr overwrites last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master between NUM_REQ requesters:
// latch a request, pulse rd_en/wr_en, watch R/B, return done/err/rdata.
module axi4_lite_req_arbiter
    import axi4_lite_Defs::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = Addr_Width,
    parameter int DATA_WIDTH = Data_Width,
    parameter int TIMEOUT    = ARB_TIMEOUT
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic                          err,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          busy,
    output arb_state_t                    dbg_state,
    axi4_lite_req_arbiter_if.master       bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rd_en_q, rd_en_d;
    logic                  wr_en_q, wr_en_d;
    logic                  busy_q, busy_d;

    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;
    logic                  rd_hs;
    logic                  wr_hs;
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign rd_hs = bus.bus_rvalid & bus.bus_rready;
    assign wr_hs = bus.bus_bvalid & bus.bus_bready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        err_d       = 1'b0;
        rsp_rdata_d = '0;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;

        // Command strobes and grant are set on the transition into ISSUE so
        // they are visible, registered, during the ISSUE cycle itself.
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ISSUE;
                    idx_d   = pick_idx;
                    we_d    = req_we[pick_idx];
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    wr_en_d = req_we[pick_idx];
                    rd_en_d = ~req_we[pick_idx];
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // A matching handshake beats a timeout landing on the same cycle.
                if (we_q ? wr_hs : rd_hs) begin
                    state_d     = DONE;
                    done_d      = gnt_q;
                    rsp_rdata_d = we_q ? '0 : bus.bus_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = idx_q;
                gnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            idx_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rsp_rdata_q <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt               = gnt_q;
    assign done              = done_q;
    assign err               = err_q;
    assign rsp_rdata         = rsp_rdata_q;
    assign busy              = busy_q;
    assign dbg_state         = state_q;
    assign bus.rd_en         = rd_en_q;
    assign bus.wr_en         = wr_en_q;
    assign bus.Read_Address  = addr_q;
    assign bus.Write_Address = addr_q;
    assign bus.Write_Data    = wdata_q;

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Bench for axi4_lite_req_arbiter: vector table, hand-written corner sequences
// and randomized traffic checked against a transaction-level round-robin model.
module tb_axi4_lite_req_arbiter;
    import axi4_lite_Defs::*;

    localparam int N  = 4;
    localparam int AW = Addr_Width;
    localparam int DW = Data_Width;
    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0]    req, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, done;
    logic            err, busy;
    logic [DW-1:0]   rsp_rdata;
    arb_state_t      dbg_state;

    axi4_lite_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    axi4_lite_req_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .ACLK(clk), .ARESET(rst), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .err(err), .rsp_rdata(rsp_rdata), .busy(busy), .dbg_state(dbg_state),
        .bus(bus_if)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int last_done_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Grants one-hot, done only to the granted requester, never both strobes.
    always @(negedge clk) begin
        if (!rst)
            check("invariant", 64'({$onehot0(gnt), |(done & ~gnt), bus_if.rd_en & bus_if.wr_en}),
                  64'(3'b100));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hs();
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rready = 1'b0;
        bus_if.bus_bvalid = 1'b0;
        bus_if.bus_bready = 1'b0;
        bus_if.bus_rdata  = $urandom;
    endtask

    task automatic set_req(input int i, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[i]            = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req[i]               = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        clear_hs();
        step();
        step();
        rst = 1'b0;
    endtask

    // Runs one transaction from the IDLE cycle. w = WAIT cycle index (0-based)
    // on which the response handshake is offered.
    task automatic txn(input string tag, input int exp_idx, input bit exp_we,
                       input logic [AW-1:0] exp_addr, input logic [DW-1:0] exp_wdata,
                       input int w, input logic [DW-1:0] rdata, input bit wrong,
                       input bit scramble, input logic [N-1:0] drop_mask,
                       input bit exp_err, input int exp_waits, input logic [DW-1:0] exp_rdata);
        logic [N-1:0] oh;
        bit got;
        int k, extra;
        oh  = N'(1) << exp_idx;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            got = (gnt != '0);
        end
        check({tag, " issue_seen"}, 64'(got), 64'(1));
        if (!got) return;
        check({tag, " gnt"},   64'(gnt), 64'(oh));
        check({tag, " wr_en"}, 64'(bus_if.wr_en), 64'(exp_we));
        check({tag, " rd_en"}, 64'(bus_if.rd_en), 64'(!exp_we));
        check({tag, " waddr"}, 64'(bus_if.Write_Address), 64'(exp_addr));
        check({tag, " raddr"}, 64'(bus_if.Read_Address), 64'(exp_addr));
        check({tag, " wdata"}, 64'(bus_if.Write_Data), 64'(exp_wdata));
        check({tag, " busy"},  64'(busy), 64'(1));
        // A handshake offered during ISSUE must not count.
        if (exp_we) begin bus_if.bus_bvalid = 1'b1; bus_if.bus_bready = 1'b1; end
        else begin bus_if.bus_rvalid = 1'b1; bus_if.bus_rready = 1'b1; end
        if (scramble) begin
            req[exp_idx]                = 1'b0;
            req_we[exp_idx]             = !exp_we;
            req_addr[exp_idx*AW +: AW]  = ~exp_addr;
            req_wdata[exp_idx*DW +: DW] = ~exp_wdata;
        end
        k = 0; extra = 0; got = 1'b0;
        for (int t = 0; t < TO + 8 && !got; t++) begin
            step();
            clear_hs();
            if (done != '0) got = 1'b1;
            else begin
                if (bus_if.rd_en || bus_if.wr_en) extra++;
                if (gnt != oh || bus_if.Write_Address != exp_addr || bus_if.Write_Data != exp_wdata)
                    extra++;
                if (k == w) begin
                    if (exp_we) begin bus_if.bus_bvalid = 1'b1; bus_if.bus_bready = 1'b1; end
                    else begin
                        bus_if.bus_rvalid = 1'b1; bus_if.bus_rready = 1'b1; bus_if.bus_rdata = rdata;
                    end
                end else if (exp_we) bus_if.bus_bvalid = 1'($urandom_range(0, 1));
                else                 bus_if.bus_rvalid = 1'($urandom_range(0, 1));
                if (wrong && k == 0) begin
                    if (exp_we) begin bus_if.bus_rvalid = 1'b1; bus_if.bus_rready = 1'b1; end
                    else begin bus_if.bus_bvalid = 1'b1; bus_if.bus_bready = 1'b1; end
                end
                k++;
            end
        end
        check({tag, " done_seen"}, 64'(got), 64'(1));
        if (!got) return;
        last_done_cyc = cyc;
        check({tag, " done"},      64'(done), 64'(oh));
        check({tag, " err"},       64'(err), 64'(exp_err));
        check({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
        check({tag, " waits"},     64'(k), 64'(exp_waits));
        check({tag, " stable"},    64'(extra), 64'(0));
        check({tag, " gnt_done"},  64'(gnt), 64'(oh));
        req = req & ~drop_mask;
        if (exp_we) begin bus_if.bus_bvalid = 1'b1; bus_if.bus_bready = 1'b1; end
        else begin bus_if.bus_rvalid = 1'b1; bus_if.bus_rready = 1'b1; end
        step();
        clear_hs();
        check({tag, " idle"}, 64'({done, gnt, busy, bus_if.rd_en, bus_if.wr_en}), 64'(0));
        check({tag, " idle_rdata"}, 64'(rsp_rdata), 64'(0));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int            idx;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            w;
        logic [DW-1:0] rdata;
        bit            wrong;
        bit            scramble;
        bit            exp_err;
        int            exp_waits;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    logic [N-1:0]  pending;
    bit            f_we    [N];
    logic [AW-1:0] f_addr  [N];
    logic [DW-1:0] f_wdata [N];

    initial begin
        bit got;
        int prev;
        int last;

        vecs[0] = '{1, 1'b1, 32'h10, 32'hDEADBEEF, 2,    32'h0,        1'b0, 1'b0, 1'b0, 3,  32'h0};
        vecs[1] = '{2, 1'b0, 32'h20, 32'h0BAD0001, 1,    32'h00001234, 1'b0, 1'b0, 1'b0, 2,  32'h00001234};
        vecs[2] = '{3, 1'b1, 32'h30, 32'hA5A5A5A5, 1000, 32'h0,        1'b0, 1'b0, 1'b1, 16, 32'h0};
        vecs[3] = '{0, 1'b0, 32'h40, 32'h0BAD0003, 0,    32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1,  32'hCAFEF00D};
        vecs[4] = '{2, 1'b0, 32'h50, 32'h0BAD0004, 5,    32'h00000055, 1'b1, 1'b0, 1'b0, 6,  32'h00000055};
        vecs[5] = '{1, 1'b0, 32'h60, 32'h0BAD0005, 15,   32'h00000077, 1'b0, 1'b0, 1'b0, 16, 32'h00000077};
        vecs[6] = '{3, 1'b0, 32'h70, 32'h0BAD0006, 16,   32'h00000099, 1'b0, 1'b0, 1'b1, 16, 32'h0};
        vecs[7] = '{0, 1'b1, 32'h80, 32'h12345678, 3,    32'h0,        1'b0, 1'b1, 1'b0, 4,  32'h0};

        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        clear_hs();
        step(); step(); step();
        check("reset outputs", 64'({gnt, done, err, busy, bus_if.rd_en, bus_if.wr_en}), 64'(0));
        check("reset rdata", 64'(rsp_rdata), 64'(0));
        check("reset addr",  64'({bus_if.Read_Address, bus_if.Write_Address}), 64'(0));
        check("reset wdata", 64'(bus_if.Write_Data), 64'(0));
        check("reset state", 64'(dbg_state), 64'(IDLE));
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            set_req(vecs[i].idx, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            txn($sformatf("vec%0d", i), vecs[i].idx, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].w, vecs[i].rdata, vecs[i].wrong, vecs[i].scramble, N'(1) << vecs[i].idx,
                vecs[i].exp_err, vecs[i].exp_waits, vecs[i].exp_rdata);
        end

        // All requesters held: order 0,1,2,3,0,1 with a done every 4 cycles.
        do_reset();
        for (int i = 0; i < N; i++) begin
            f_we[i] = 1'(i % 2); f_addr[i] = 32'h100 + 32'(4 * i); f_wdata[i] = $urandom;
            set_req(i, f_we[i], f_addr[i], f_wdata[i]);
        end
        prev = 0;
        for (int n = 0; n < 6; n++) begin
            int e;
            e = n % N;
            txn($sformatf("rr%0d", n), e, f_we[e], f_addr[e], f_wdata[e], 0, 32'h3000 + 32'(n),
                1'b0, 1'b0, (n == 5) ? {N{1'b1}} : '0, 1'b0, 1,
                f_we[e] ? 32'h0 : 32'h3000 + 32'(n));
            if (n > 0) check($sformatf("rr%0d spacing", n), 64'(last_done_cyc - prev), 64'(4));
            prev = last_done_cyc;
        end

        // Reset during WAIT: silent abandon, late rvalid ignored, pointer back to 0.
        set_req(0, 1'b0, 32'h200, 32'h0);
        txn("rst_pre", 0, 1'b0, 32'h200, 32'h0, 0, 32'h1111, 1'b0, 1'b0, 4'b0001, 1'b0, 1, 32'h1111);
        set_req(2, 1'b0, 32'h204, 32'h0);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            got = (gnt != '0);
        end
        check("rst issue_seen", 64'(got), 64'(1));
        step(); step();
        check("rst in_wait", 64'(dbg_state), 64'(WAIT));
        rst = 1'b1;
        step();
        check("rst outputs", 64'({gnt, done, err, busy, bus_if.rd_en, bus_if.wr_en}), 64'(0));
        check("rst rdata", 64'(rsp_rdata), 64'(0));
        check("rst addr",  64'({bus_if.Read_Address, bus_if.Write_Address}), 64'(0));
        check("rst wdata", 64'(bus_if.Write_Data), 64'(0));
        rst = 1'b0;
        req = '0;
        bus_if.bus_rvalid = 1'b1; bus_if.bus_rready = 1'b1; bus_if.bus_rdata = 32'h5555AAAA;
        for (int t = 0; t < 3; t++) begin
            step();
            clear_hs();
            check("rst quiet", 64'({done, gnt, busy}), 64'(0));
        end
        set_req(0, 1'b1, 32'h300, 32'h0000F00D);
        set_req(3, 1'b0, 32'h304, 32'h0);
        txn("rst_post", 0, 1'b1, 32'h300, 32'h0000F00D, 1, 32'h0, 1'b0, 1'b0, 4'b1001,
            1'b0, 2, 32'h0);

        // Randomized traffic against the round-robin model.
        do_reset();
        last = N - 1;
        pending = '0;
        for (int n = 0; n < 40; n++) begin
            int pick, w, r;
            bit wrong, x_err;
            logic [DW-1:0] rd;
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && $urandom_range(0, 1) == 1) begin
                    f_we[i] = 1'($urandom_range(0, 1)); f_addr[i] = $urandom; f_wdata[i] = $urandom;
                    set_req(i, f_we[i], f_addr[i], f_wdata[i]);
                    pending[i] = 1'b1;
                end
            end
            if (pending == '0) begin
                r = int'($urandom_range(0, N - 1));
                f_we[r] = 1'($urandom_range(0, 1)); f_addr[r] = $urandom; f_wdata[r] = $urandom;
                set_req(r, f_we[r], f_addr[r], f_wdata[r]);
                pending[r] = 1'b1;
            end
            pick = -1;
            for (int k = 1; k <= N; k++)
                if (pick < 0 && pending[(last + k) % N]) pick = (last + k) % N;
            w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TO - 2, TO + 1))
                                           : int'($urandom_range(0, 6));
            wrong = ($urandom_range(0, 3) == 0) && (w > 0);
            rd    = $urandom;
            x_err = (w >= TO);
            txn($sformatf("rand%0d", n), pick, f_we[pick], f_addr[pick], f_wdata[pick], w, rd,
                wrong, 1'b0, N'(1) << pick, x_err, x_err ? TO : w + 1,
                (!f_we[pick] && !x_err) ? rd : 32'h0);
            pending[pick] = 1'b0;
            last = pick;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_req_arbiter.md
Name: axi4_lite_req_arbiter

Overview:
Round-robin arbiter and transaction sequencer that shares the single axi4_lite_master between NUM_REQ requesters (testbench drivers or on-chip clients). It latches one request, issues a one-cycle rd_en/wr_en pulse with a stable address and data to the master, and watches the bus response handshake. It then returns completion, read data and a timeout error to the granted requester. It sits between the requesters and the master's command inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, Addr_Width (axi4_lite_Defs), address width
DATA_WIDTH, Data_Width (axi4_lite_Defs), data width
TIMEOUT, 256, WAIT cycles before a transaction is abandoned (>=2)

Ports:
ACLK  in  1  clock; all logic on posedge
ARESET  in  1  synchronous reset, active-high
req  in  NUM_REQ  request per requester; held until its done pulse
req_we  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
gnt  out  NUM_REQ  one-hot grant, high from ISSUE through DONE
done  out  NUM_REQ  one-cycle completion pulse to the granted requester
err  out  1  valid with done; 1 = timeout
rsp_rdata  out  DATA_WIDTH  read data, valid with done for reads, else 0
busy  out  1  FSM not in IDLE
rd_en  out  1  one-cycle read command to master
wr_en  out  1  one-cycle write command to master
Read_Address  out  ADDR_WIDTH  latched address, to master
Write_Address  out  ADDR_WIDTH  latched address, to master
Write_Data  out  DATA_WIDTH  latched write data, to master
bus_rvalid, bus_rready  in  1 each  monitored R channel handshake
bus_rdata  in  DATA_WIDTH  monitored R channel data
bus_bvalid, bus_bready  in  1 each  monitored B channel handshake

Behaviour:
- Reset: state=IDLE. Outputs gnt, done, err, rsp_rdata, busy, rd_en, wr_en, addresses and Write_Data all 0. Pointer ptr=NUM_REQ-1, so requester 0 has first priority. Timeout counter=0. Reset mid-transaction abandons it silently; no done is issued.
- FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All outputs are registered.
- IDLE: if |req, select the first set bit searching from (ptr+1) mod NUM_REQ upward with wrap-around. Latch idx, we, addr and wdata; go to ISSUE. With no request, stay in IDLE.
- ISSUE, one cycle: gnt[idx]=1. wr_en=1 if we, else rd_en=1; never both. Read_Address=Write_Address=latched addr. Write_Data=latched wdata. Counter cleared. Go to WAIT.
- Addresses and Write_Data hold stable from ISSUE until the next ISSUE. rd_en/wr_en are 0 in every other state.
- WAIT completion: a write completes on bus_bvalid&bus_bready; a read completes on bus_rvalid&bus_rready, capturing bus_rdata. The handshake of the wrong type is ignored.
- WAIT timeout: otherwise counter++. When counter reaches TIMEOUT-1 with no handshake, go to DONE with err=1.
- Simultaneous handshake and timeout: the handshake wins and err=0.
- Fastest completion: handshake in the first WAIT cycle.
- DONE, one cycle: done[idx]=1. err valid. rsp_rdata=captured data for a completed read, 0 for writes or timeouts. ptr<=idx. gnt drops the next cycle; go to IDLE.
- Throughput: minimum 4 cycles per transaction (IDLE, ISSUE, WAIT, DONE).
- Request changes: req, addr or we changing after latch have no effect on the current transaction. A requester dropping req early still receives its done.
- Handshakes seen while in IDLE, ISSUE or DONE are ignored.

Decomposition:
- axi4_lite_Defs gains arb_state_t (IDLE, ISSUE, WAIT, DONE) and the ARB_TIMEOUT default constant; Addr_Width and Data_Width come from there.
- One sub-module, rr_pick: combinational round-robin selector. Inputs req and ptr; outputs idx and a valid flag. It is reusable by future arbiters.

Test Plan:
1. req[1], we=1, addr=0x10, wdata=0xDEADBEEF; bvalid&bready 3 cycles after ISSUE -> single wr_en pulse, Write_Address=0x10, Write_Data=0xDEADBEEF, done[1] pulse, err=0, rsp_rdata=0.
2. req[2] read at addr=0x20; rvalid&rready with rdata=0x00001234 -> single rd_en pulse, done[2] with rsp_rdata=0x00001234, err=0.
3. All 4 req held high with immediate responses -> grant order 0,1,2,3,0,1; exactly one gnt bit at a time; done every 4 cycles.
4. TIMEOUT=16, write with no bvalid -> done[idx] with err=1 after exactly 16 WAIT cycles. Then a read to a different requester completes normally.
5. Read outstanding plus bvalid&bready pulse -> ignored and the transaction stays in WAIT. A handshake on the cycle the counter hits TIMEOUT-1 -> err=0.
6. ARESET asserted in WAIT -> next cycle all outputs 0, busy=0, no done. A late rvalid is ignored, and the next grant goes to requester 0.
